regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter N, default 4, register address width; SHALL match the attached register file.
REQ-002 Parameter W, default 8, data word width.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-007 cmd_op  input  3  operation code (REQ-015).
REQ-008 cmd_rd / cmd_rs1 / cmd_rs2  input  N each  destination and source register addresses.
REQ-009 cmd_imm  input  W  immediate operand.
REQ-010 rf_we  output  1  register file write enable.
REQ-011 rf_addr_rd / rf_addr_rs1 / rf_addr_rs2  output  N each  register file addresses.
REQ-012 rf_data_in  output  W  register file write data; rf_rs1 / rf_rs2  input  W each  register file combinational read data.
REQ-013 done  output  1  one-cycle pulse marking command completion; result  output  W  value computed by the last completed command.
REQ-014 busy  output  1  command in flight; op_count  output  16  completed-command counter.

Function
REQ-015 Opcodes: 000 ADD rs1+rs2; 001 SUB rs1-rs2; 010 AND; 011 OR; 100 XOR; 101 LDI rd=cmd_imm; 110 MOV rd=rs1; 111 NOP with no write.
REQ-016 FSM states IDLE, READ, EXEC, WB; IDLE->READ on cmd_valid&&cmd_ready; READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-017 cmd_ready SHALL be 1 only in IDLE; busy SHALL equal !cmd_ready.
REQ-018 On acceptance, op, rd, rs1, rs2 and imm SHALL be latched; inputs changing afterwards SHALL have no effect on the command in flight.
REQ-019 rf_addr_rs1/rs2/rd SHALL drive the latched addresses from READ through WB and SHALL hold their last values in IDLE.
REQ-020 In READ, rf_rs1 and rf_rs2 SHALL be registered into operand registers.
REQ-021 In EXEC, the result SHALL be computed from the operand registers and registered; the width is W and the carry/borrow is discarded unless REQ-031 applies.
REQ-022 In WB, rf_we SHALL be 1 for exactly one cycle with rf_data_in equal to the result, except for NOP (rf_we=0); rf_we SHALL be 0 in every other state.
REQ-023 done SHALL pulse high in the WB cycle, including for NOP; result SHALL update in that same cycle and hold until the next WB.
REQ-024 Latency: for a command accepted in cycle T, the write and done occur in cycle T+3; peak throughput is one command per 4 cycles.
REQ-025 rd=0 SHALL still issue rf_we; the register file discards the write, and result SHALL still carry the computed value.
REQ-026 rd equal to rs1 or rs2 SHALL be legal: operands are captured in READ, before the WB write.
REQ-027 A back-to-back command reading the previous rd SHALL observe the written value, with no hazard stall required.
REQ-028 op_count SHALL increment by 1 on each done pulse and wrap from 0xFFFF to 0x0000.

Reset
REQ-029 With rst=1 at a rising edge: state=IDLE, cmd_ready=1, busy=0, rf_we=0, done=0, result=0, op_count=0, rf_addr_*=0, operand registers=0, rf_data_in=0.
REQ-030 rst asserted mid-command SHALL abort it with no rf_we pulse, no done pulse and no op_count change.

Configuration
REQ-031 With macro REGSEQ_SAT_EN defined: ADD saturates to 2^W-1 and SUB saturates to 0; without it, ADD and SUB wrap modulo 2^W. All other opcodes are unaffected either way.

Verification
REQ-032 Reset, then LDI r3=0x5A -> rf_we pulse in T+3 with addr 3, data 0x5A; done=1; op_count=1.
REQ-033 r1=0xF0, r2=0x20, then ADD r4=r1+r2 -> result 0x10 without REGSEQ_SAT_EN, 0xFF with it; SUB r5=r2-r1 -> result 0x30 without it, 0x00 with it.
REQ-034 Hold cmd_valid=1 continuously with two distinct commands -> the second is accepted only in the cycle after the first's done; cmd_ready=0 for 3 cycles between acceptances.
REQ-035 ADD r1=r1+r1 with r1=0x07 -> writes 0x0E; an immediately following MOV r2=r1 -> writes 0x0E.
REQ-036 Assert rst in the EXEC cycle of an LDI r6=0x33 -> no rf_we, no done, op_count=0, and a later read of r6 returns 0.
REQ-037 NOP, then XOR r0=r1^r2 -> NOP: done=1, rf_we=0; XOR: rf_we=1 with addr 0, r0 still reads 0, op_count=2.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Four-phase command sequencer (IDLE/READ/EXEC/WB) driving an external register file.
// Define REGSEQ_SAT_EN to make ADD/SUB saturate instead of wrapping.
module regfile_sequencer #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [N-1:0] cmd_rd,
    input  logic [N-1:0] cmd_rs1,
    input  logic [N-1:0] cmd_rs2,
    input  logic [W-1:0] cmd_imm,
    output logic         rf_we,
    output logic [N-1:0] rf_addr_rd,
    output logic [N-1:0] rf_addr_rs1,
    output logic [N-1:0] rf_addr_rs2,
    output logic [W-1:0] rf_data_in,
    input  logic [W-1:0] rf_rs1,
    input  logic [W-1:0] rf_rs2,
    output logic         done,
    output logic [W-1:0] result,
    output logic         busy,
    output logic [15:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_LDI = 3'b101,
        OP_MOV = 3'b110,
        OP_NOP = 3'b111
    } op_e;

    state_e       state, state_nx;
    op_e          op_q;
    logic [N-1:0] rd_q, rs1_q, rs2_q;
    logic [W-1:0] imm_q;
    logic [W-1:0] opa_q, opb_q;
    logic [W-1:0] res_q;
    logic [W-1:0] alu;
    logic [15:0]  cnt_q;

`ifdef REGSEQ_SAT_EN
    logic [W:0] sum_ext, diff_ext;
    assign sum_ext  = {1'b0, opa_q} + {1'b0, opb_q};
    assign diff_ext = {1'b0, opa_q} - {1'b0, opb_q};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (cmd_valid) state_nx = READ;
            READ: state_nx = EXEC;
            EXEC: state_nx = WB;
            WB:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        alu = '0;
        unique case (op_q)
`ifdef REGSEQ_SAT_EN
            OP_ADD: alu = sum_ext[W] ? '1 : sum_ext[W-1:0];
            OP_SUB: alu = diff_ext[W] ? '0 : diff_ext[W-1:0];
`else
            OP_ADD: alu = opa_q + opb_q;
            OP_SUB: alu = opa_q - opb_q;
`endif
            OP_AND: alu = opa_q & opb_q;
            OP_OR:  alu = opa_q | opb_q;
            OP_XOR: alu = opa_q ^ opb_q;
            OP_LDI: alu = imm_q;
            OP_MOV: alu = opa_q;
            OP_NOP: alu = '0;
            default: alu = '0;
        endcase
    end

    // Command fields are captured only on acceptance, so the addresses hold through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= OP_NOP;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                op_q  <= op_e'(cmd_op);
                rd_q  <= cmd_rd;
                rs1_q <= cmd_rs1;
                rs2_q <= cmd_rs2;
                imm_q <= cmd_imm;
            end
            if (state == READ) begin
                opa_q <= rf_rs1;
                opb_q <= rf_rs2;
            end
            if (state == EXEC) begin
                res_q <= alu;
            end
            if (state == WB) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = (state == WB);
    assign rf_we       = (state == WB) && (op_q != OP_NOP);
    assign rf_addr_rd  = rd_q;
    assign rf_addr_rs1 = rs1_q;
    assign rf_addr_rs2 = rs2_q;
    assign rf_data_in  = res_q;
    // res_q loads at the EXEC->WB edge, so result changes exactly in the WB cycle.
    assign result      = res_q;
    assign op_count    = cnt_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed self-checking bench for regfile_sequencer with a behavioural 16x8 register file (r0 reads 0).
module tb_regfile_sequencer;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [N-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [W-1:0] cmd_imm = '0;
    logic         rf_we;
    logic [N-1:0] rf_addr_rd, rf_addr_rs1, rf_addr_rs2;
    logic [W-1:0] rf_data_in, rf_rs1, rf_rs2;
    logic         done;
    logic [W-1:0] result;
    logic         busy;
    logic [15:0]  op_count;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] rf [16] = '{default: '0};

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rf_we && rf_addr_rd != '0) rf[rf_addr_rd] <= rf_data_in;
    end

    assign rf_rs1 = (rf_addr_rs1 == '0) ? '0 : rf[rf_addr_rs1];
    assign rf_rs2 = (rf_addr_rs2 == '0) ? '0 : rf[rf_addr_rs2];

    regfile_sequencer #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .rf_we(rf_we), .rf_addr_rd(rf_addr_rd), .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
        .rf_data_in(rf_data_in), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .done(done), .result(result), .busy(busy), .op_count(op_count)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Issues one command, scrambles the inputs after acceptance, and samples the WB cycle (T+3).
    // Returns in the IDLE cycle following WB.
    task automatic drive_cmd(input logic [2:0] op, input logic [N-1:0] rd, input logic [N-1:0] rs1,
                             input logic [N-1:0] rs2, input logic [W-1:0] imm,
                             output logic we, output logic [N-1:0] addr, output logic [W-1:0] data,
                             output logic dn, output logic [W-1:0] res, output logic early);
        int unsigned n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout cmd_ready=%0b want 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_rd = N'($urandom); cmd_rs1 = N'($urandom);
        cmd_rs2 = N'($urandom); cmd_imm = W'($urandom);
        early = rf_we | done | cmd_ready;
        @(posedge clk); #1;
        early = early | rf_we | done | cmd_ready;
        @(posedge clk); #1;
        we = rf_we; addr = rf_addr_rd; data = rf_data_in; dn = done; res = result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_handshake ready=%0b busy=%0b want 1 0", cmd_ready, busy);
        end
        checks++;
        if (rf_we !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_pulses we=%0b done=%0b want 0 0", rf_we, done);
        end
        checks++;
        if (result !== 8'h00 || rf_data_in !== 8'h00 || op_count !== 16'h0) begin
            errors++; $display("FAIL reset_data result=%h data=%h cnt=%h want 0", result, rf_data_in, op_count);
        end
        checks++;
        if (rf_addr_rd !== 4'h0 || rf_addr_rs1 !== 4'h0 || rf_addr_rs2 !== 4'h0) begin
            errors++; $display("FAIL reset_addr rd=%h rs1=%h rs2=%h want 0", rf_addr_rd, rf_addr_rs1, rf_addr_rs2);
        end
    endtask

    task automatic test_ldi();
        logic we, dn, early;
        logic [N-1:0] addr;
        logic [W-1:0] data, res;
        drive_cmd(3'b101, 4'd3, 4'd0, 4'd0, 8'h5A, we, addr, data, dn, res, early);
        checks++;
        if (early !== 1'b0) begin
            errors++; $display("FAIL ldi_early early=%0b want 0", early);
        end
        checks++;
        if (we !== 1'b1 || addr !== 4'd3 || data !== 8'h5A || dn !== 1'b1) begin
            errors++; $display("FAIL ldi_wb we=%0b addr=%h data=%h done=%0b want 1 3 5a 1", we, addr, data, dn);
        end
        checks++;
        if (op_count !== 16'd1) begin
            errors++; $display("FAIL ldi_count op_count=%0d want 1", op_count);
        end
        checks++;
        if (rf_addr_rd !== 4'd3 || rf_we !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL ldi_idle_hold rd=%h we=%0b done=%0b want 3 0 0", rf_addr_rd, rf_we, done);
        end
    endtask

    task automatic test_alu();
        logic we, dn, early;
        logic [N-1:0] addr;
        logic [W-1:0] data, res, exp_add, exp_sub;
`ifdef REGSEQ_SAT_EN
        exp_add = 8'hFF; exp_sub = 8'h00;
`else
        exp_add = 8'h10; exp_sub = 8'h30;
`endif
        drive_cmd(3'b101, 4'd1, 4'd0, 4'd0, 8'hF0, we, addr, data, dn, res, early);
        drive_cmd(3'b101, 4'd2, 4'd0, 4'd0, 8'h20, we, addr, data, dn, res, early);
        drive_cmd(3'b000, 4'd4, 4'd1, 4'd2, 8'h00, we, addr, data, dn, res, early);
        checks++;
        if (we !== 1'b1 || addr !== 4'd4 || data !== exp_add || res !== exp_add) begin
            errors++; $display("FAIL add we=%0b addr=%h data=%h result=%h want 1 4 %h", we, addr, data, res, exp_add);
        end
        drive_cmd(3'b001, 4'd5, 4'd2, 4'd1, 8'h00, we, addr, data, dn, res, early);
        checks++;
        if (we !== 1'b1 || addr !== 4'd5 || data !== exp_sub || res !== exp_sub) begin
            errors++; $display("FAIL sub we=%0b addr=%h data=%h result=%h want 1 5 %h", we, addr, data, res, exp_sub);
        end
        drive_cmd(3'b010, 4'd9, 4'd1, 4'd2, 8'h00, we, addr, data, dn, res, early);
        checks++;
        if (data !== 8'h20 || res !== 8'h20) begin
            errors++; $display("FAIL and data=%h result=%h want 20", data, res);
        end
        drive_cmd(3'b011, 4'd10, 4'd2, 4'd5, 8'h00, we, addr, data, dn, res, early);
        checks++;
        if (data !== (8'h20 | exp_sub)) begin
            errors++; $display("FAIL or data=%h want %h", data, 8'h20 | exp_sub);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned gap = 0;
        int unsigned n = 0;
        logic saw_done = 1'b0;
        logic we, dn, early;
        logic [N-1:0] addr;
        logic [W-1:0] data, res;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'b101; cmd_rd = 4'd7; cmd_imm = 8'h11;
        @(posedge clk); #1;
        cmd_rd = 4'd8; cmd_imm = 8'h22;
        @(negedge clk);
        while (!cmd_ready && n < 10) begin
            gap++;
            if (done) saw_done = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (gap != 3 || saw_done !== 1'b1) begin
            errors++; $display("FAIL b2b_gap gap=%0d done_seen=%0b want 3 1", gap, saw_done);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (rf_we !== 1'b1 || rf_addr_rd !== 4'd8 || rf_data_in !== 8'h22 || done !== 1'b1) begin
            errors++; $display("FAIL b2b_second we=%0b addr=%h data=%h done=%0b want 1 8 22 1",
                               rf_we, rf_addr_rd, rf_data_in, done);
        end
        @(posedge clk); #1;
        drive_cmd(3'b110, 4'd11, 4'd7, 4'd0, 8'h00, we, addr, data, dn, res, early);
        checks++;
        if (res !== 8'h11) begin
            errors++; $display("FAIL b2b_first_written result=%h want 11", res);
        end
    endtask

    task automatic test_hazard();
        logic we, dn, early;
        logic [N-1:0] addr;
        logic [W-1:0] data, res;
        drive_cmd(3'b101, 4'd1, 4'd0, 4'd0, 8'h07, we, addr, data, dn, res, early);
        drive_cmd(3'b000, 4'd1, 4'd1, 4'd1, 8'h00, we, addr, data, dn, res, early);
        checks++;
        if (we !== 1'b1 || addr !== 4'd1 || data !== 8'h0E) begin
            errors++; $display("FAIL hazard_add we=%0b addr=%h data=%h want 1 1 0e", we, addr, data);
        end
        drive_cmd(3'b110, 4'd2, 4'd1, 4'd0, 8'h00, we, addr, data, dn, res, early);
        checks++;
        if (we !== 1'b1 || addr !== 4'd2 || data !== 8'h0E) begin
            errors++; $display("FAIL hazard_mov we=%0b addr=%h data=%h want 1 2 0e", we, addr, data);
        end
    endtask

    task automatic test_abort();
        logic seen = 1'b0;
        logic we, dn, early;
        logic [N-1:0] addr;
        logic [W-1:0] data, res;
        do_reset();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'b101; cmd_rd = 4'd6; cmd_imm = 8'h33;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rf_we || done) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0 || op_count !== 16'd0) begin
            errors++; $display("FAIL abort pulse_seen=%0b op_count=%0d want 0 0", seen, op_count);
        end
        drive_cmd(3'b110, 4'd12, 4'd6, 4'd0, 8'h00, we, addr, data, dn, res, early);
        checks++;
        if (res !== 8'h00 || op_count !== 16'd1) begin
            errors++; $display("FAIL abort_readback result=%h op_count=%0d want 00 1", res, op_count);
        end
    endtask

    task automatic test_nop_xor();
        logic we, dn, early;
        logic [N-1:0] addr;
        logic [W-1:0] data, res;
        drive_cmd(3'b101, 4'd1, 4'd0, 4'd0, 8'hF0, we, addr, data, dn, res, early);
        drive_cmd(3'b101, 4'd2, 4'd0, 4'd0, 8'h20, we, addr, data, dn, res, early);
        do_reset();
        drive_cmd(3'b111, 4'd5, 4'd1, 4'd2, 8'hAA, we, addr, data, dn, res, early);
        checks++;
        if (dn !== 1'b1 || we !== 1'b0 || early !== 1'b0) begin
            errors++; $display("FAIL nop done=%0b we=%0b early=%0b want 1 0 0", dn, we, early);
        end
        drive_cmd(3'b100, 4'd0, 4'd1, 4'd2, 8'h00, we, addr, data, dn, res, early);
        checks++;
        if (we !== 1'b1 || addr !== 4'd0 || res !== 8'hD0 || op_count !== 16'd2) begin
            errors++; $display("FAIL xor_r0 we=%0b addr=%h result=%h cnt=%0d want 1 0 d0 2", we, addr, res, op_count);
        end
        drive_cmd(3'b110, 4'd3, 4'd0, 4'd0, 8'h00, we, addr, data, dn, res, early);
        checks++;
        if (res !== 8'h00) begin
            errors++; $display("FAIL r0_readback result=%h want 00", res);
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu();
        test_back_to_back();
        test_hazard();
        test_abort();
        test_nop_xor();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
